matmul_result_unpacker: RTL and testbench

- Drain-side consumer of the matrix-multiplier result bus.
- Captures each 256-bit result row (8 × 32-bit signed elements), presented as a single-cycle valid pulse with no back-pressure.
- Buffers rows in a small row FIFO and replays them one element at a time on a 32-bit valid/ready stream toward memory or the host interface.
- Flags any row lost to overflow.

---
 rtl/matmul_result_unpacker.sv | 115 +++++++++++
 tb/tb_matmul_result_unpacker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_result_unpacker.sv
// Row FIFO that buffers 256-bit matmul result rows and replays them one element per handshake.
// Optional build macro UNPACK_MSB_FIRST_EN: emit each row from element NUM_ELEM-1 down to 0.
module matmul_result_unpacker #(
  parameter int ELEM_W   = 32,
  parameter int NUM_ELEM = 8,
  parameter int DEPTH    = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         vld_i,
  input  logic [ELEM_W*NUM_ELEM-1:0]   matmul_i,
  input  logic                         clr_i,
  output logic [ELEM_W-1:0]            elem_o,
  output logic                         elem_vld_o,
  input  logic                         elem_rdy_i,
  output logic [$clog2(NUM_ELEM)-1:0]  elem_idx_o,
  output logic                         row_last_o,
  output logic                         full_o,
  output logic                         ovf_o
);

  localparam int ROW_W = ELEM_W * NUM_ELEM;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(NUM_ELEM);
  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(NUM_ELEM - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ROW_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  pos;
  logic              ovf_q;
  logic              xfer;
  logic              pop_row;
  logic              has_space;
  logic              push;
  logic [IDX_W-1:0]  idx;
  logic [ROW_W-1:0]  head;
  logic [ELEM_W-1:0] head_elems [NUM_ELEM];

  assign elem_vld_o = (count != '0);
  assign xfer       = elem_vld_o && elem_rdy_i;
  assign pop_row    = xfer && (pos == LAST_POS);
  // A full FIFO still takes a row when the head row retires on the same edge.
  assign has_space  = (count != FULL_CNT) || pop_row;
  assign push       = vld_i && has_space;

  // pos counts emission order; idx is the true element index it maps to.
`ifdef UNPACK_MSB_FIRST_EN
  assign idx = LAST_POS - pos;
`else
  assign idx = pos;
`endif

  assign head = mem[rd_ptr];

  always_comb begin
    for (int k = 0; k < NUM_ELEM; k++) begin
      head_elems[k] = head[k*ELEM_W +: ELEM_W];
    end
  end

  // Gating keeps outputs at zero when empty, since the row storage is never reset.
  assign elem_o     = elem_vld_o ? head_elems[idx] : '0;
  assign elem_idx_o = elem_vld_o ? idx : '0;
  assign row_last_o = elem_vld_o && (pos == LAST_POS);
  assign full_o     = (count == FULL_CNT);
  assign ovf_o      = ovf_q;

  // NOTE: the row storage has no reset; count and pointers alone define what is valid,
  // and leaving the wide array unreset lets it map onto plain flops or RAM.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= matmul_i;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pos    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (xfer) begin
        if (pos == LAST_POS) begin
          pos    <= '0;
          rd_ptr <= rd_ptr + 1'b1;
        end else begin
          pos <= pos + 1'b1;
        end
      end
      case ({push, pop_row})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as clr_i leaves the flag set.
      if (vld_i && !has_space) begin
        ovf_q <= 1'b1;
      end else if (clr_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matmul_result_unpacker.sv
// Scoreboard bench for matmul_result_unpacker: expected elements are queued on row pushes
// and compared every cycle the head is presented.
module tb_matmul_result_unpacker;

  localparam int ELEM_W   = 32;
  localparam int NUM_ELEM = 8;
  localparam int DEPTH    = 2;
  localparam int ROW_W    = ELEM_W * NUM_ELEM;
`ifdef UNPACK_MSB_FIRST_EN
  localparam logic [2:0] LAST_IDX   = 3'd0;
  localparam logic [2:0] AFTER3_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX   = 3'd7;
  localparam logic [2:0] AFTER3_IDX = 3'd3;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  logic             clk;
  logic             rst_i;
  logic             vld_i;
  logic [ROW_W-1:0] matmul_i;
  logic             clr_i;
  logic [31:0]      elem_o;
  logic             elem_vld_o;
  logic             elem_rdy_i;
  logic [2:0]       elem_idx_o;
  logic             row_last_o;
  logic             full_o;
  logic             ovf_o;

  exp_t sb[$];
  int   model_rows;
  logic model_ovf;
  int   n_tests;
  int   n_fail;

  matmul_result_unpacker #(.ELEM_W(ELEM_W), .NUM_ELEM(NUM_ELEM), .DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .vld_i      (vld_i),
    .matmul_i   (matmul_i),
    .clr_i      (clr_i),
    .elem_o     (elem_o),
    .elem_vld_o (elem_vld_o),
    .elem_rdy_i (elem_rdy_i),
    .elem_idx_o (elem_idx_o),
    .row_last_o (row_last_o),
    .full_o     (full_o),
    .ovf_o      (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ROW_W-1:0] make_row(input logic [31:0] base);
    logic [ROW_W-1:0] r;
    for (int k = 0; k < NUM_ELEM; k++) r[k*ELEM_W +: ELEM_W] = base + 32'(k);
    return r;
  endfunction

  // Monitor and reference model; decisions use pre-edge values, mirroring the next posedge.
  always @(negedge clk) begin
    logic             pop_row;
    logic [ROW_W-1:0] r;
    exp_t             e;
    int               k;
    if (!rst_i) begin
      pop_row = 1'b0;
      check("elem_vld", elem_vld_o, (sb.size() != 0));
      check("full", full_o, (model_rows == DEPTH));
      check("ovf", ovf_o, model_ovf);
      if (sb.size() != 0) begin
        check("elem_data", elem_o, sb[0].data);
        check("elem_idx", elem_idx_o, sb[0].idx);
        check("row_last", row_last_o, sb[0].last);
        if (elem_rdy_i) begin
          e = sb.pop_front();
          pop_row = e.last;
        end
      end
      if (pop_row) model_rows--;
      if (clr_i) model_ovf = 1'b0;
      if (vld_i) begin
        if (model_rows - (pop_row ? 0 : 0) < DEPTH || pop_row) begin
          r = matmul_i;
          for (int j = 0; j < NUM_ELEM; j++) begin
`ifdef UNPACK_MSB_FIRST_EN
            k = NUM_ELEM - 1 - j;
`else
            k = j;
`endif
            e.data = r[k*ELEM_W +: ELEM_W];
            e.idx  = 3'(k);
            e.last = (j == NUM_ELEM - 1);
            sb.push_back(e);
          end
          model_rows++;
        end else begin
          model_ovf = 1'b1;
        end
      end
    end
  end

  task automatic push_row(input logic [ROW_W-1:0] row, input logic clr);
    @(posedge clk); #1;
    vld_i = 1'b1; matmul_i = row; clr_i = clr;
    @(posedge clk); #1;
    vld_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; clr_i = 1'b1;
    @(posedge clk); #1; clr_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && (sb.size() != 0); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check(tag, sb.size(), 0);
  endtask

  // Leaves the bench at posedge+1 of the cycle where the given index is presented.
  task automatic wait_idx(input string tag, input logic [2:0] target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      hit = elem_vld_o && (elem_idx_o == target);
    end
    check(tag, hit, 1'b1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    model_rows = 0; model_ovf = 1'b0;
    rst_i = 1'b1; vld_i = 1'b0; clr_i = 1'b0; elem_rdy_i = 1'b0; matmul_i = '0;
    #1;
    check("rst_elem_vld", elem_vld_o, 1'b0);
    check("rst_elem", elem_o, 32'h0);
    check("rst_idx", elem_idx_o, 3'd0);
    check("rst_last", row_last_o, 1'b0);
    check("rst_full", full_o, 1'b0);
    check("rst_ovf", ovf_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    // Single row, always ready.
    elem_rdy_i = 1'b1;
    push_row(make_row(32'd1), 1'b0);
    wait_drain("single_drain");

    // Back-pressure: ready pattern 1,0,0,1 repeating.
    push_row(make_row(32'd1), 1'b0);
    for (int i = 0; i < 40; i++) begin
      elem_rdy_i = ((i % 4) == 0) || ((i % 4) == 3);
      @(posedge clk); #1;
    end
    elem_rdy_i = 1'b1;
    wait_drain("bp_drain");

    // Fill, overflow, drain, clear.
    elem_rdy_i = 1'b0;
    push_row(make_row(32'h100), 1'b0);
    push_row(make_row(32'h200), 1'b0);
    check("full_after_b", full_o, 1'b1);
    push_row(make_row(32'h300), 1'b0);
    @(posedge clk); #1;
    check("ovf_after_c", ovf_o, 1'b1);
    elem_rdy_i = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_sticky", ovf_o, 1'b1);
    pulse_clr();
    check("ovf_cleared", ovf_o, 1'b0);

    // Push into a full FIFO on the cycle the head row's last element retires.
    elem_rdy_i = 1'b0;
    push_row(make_row(32'h400), 1'b0);
    push_row(make_row(32'h500), 1'b0);
    elem_rdy_i = 1'b1;
    wait_idx("simul_wait", LAST_IDX);
    vld_i = 1'b1; matmul_i = make_row(32'h600);
    @(posedge clk); #1;
    vld_i = 1'b0;
    check("simul_full", full_o, 1'b1);
    check("simul_ovf", ovf_o, 1'b0);
    wait_drain("simul_drain");

    // Overflow and clear in the same cycle: set wins.
    elem_rdy_i = 1'b0;
    push_row(make_row(32'h700), 1'b0);
    push_row(make_row(32'h800), 1'b0);
    push_row(make_row(32'h900), 1'b1);
    check("clr_vs_ovf", ovf_o, 1'b1);
    elem_rdy_i = 1'b1;
    wait_drain("clr_ovf_drain");
    pulse_clr();

    // Reset mid-row after three elements.
    push_row(make_row(32'hA00), 1'b0);
    wait_idx("midrow_wait", AFTER3_IDX);
    rst_i = 1'b1;
    #1;
    check("mid_rst_vld", elem_vld_o, 1'b0);
    check("mid_rst_elem", elem_o, 32'h0);
    check("mid_rst_idx", elem_idx_o, 3'd0);
    check("mid_rst_last", row_last_o, 1'b0);
    check("mid_rst_full", full_o, 1'b0);
    sb.delete();
    model_rows = 0;
    model_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    push_row(make_row(32'hB00), 1'b0);
    wait_drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
